// File: rtl/fifo_c.sv
//==============================================================================
// Module      : fifo_c
// Description : 8-deep synchronous lane FIFO ahead of the 2:1 stream mux.
//               Optional almost_full/almost_empty decode: FIFO_C_ALMOST_FLAGS_EN
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module fifo_c #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AFULL_TH   = 6,
  parameter int unsigned AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int unsigned           c_DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   c_DEPTH_CNT = (ADDR_WIDTH+1)'(c_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;

  logic w_pop_acc;
  logic w_push_acc;
  logic w_err_evt;

  // Thresholds beyond the depth would make the almost flags meaningless.
  if ((AFULL_TH > c_DEPTH) || (AEMPTY_TH > c_DEPTH)) begin : g_th_check
    $error("fifo_c: almost thresholds exceed FIFO depth");
  end

  assign full  = (r_count == c_DEPTH_CNT);
  assign empty = (r_count == '0);

  // A pop frees a slot in the same edge, so a push into a full FIFO is
  // still accepted when paired with a pop.
  assign w_pop_acc  = pop && !empty;
  assign w_push_acc = push && (!full || w_pop_acc);
  assign w_err_evt  = (push && !w_push_acc) || (pop && empty);

  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end

      if (w_pop_acc) begin
        r_rd_ptr  <= r_rd_ptr + ADDR_WIDTH'(1);
        data_out  <= r_mem[r_rd_ptr];
        valid_out <= 1'b1;
      end else begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end

      if (w_push_acc && !w_pop_acc) begin
        r_count <= r_count + (ADDR_WIDTH+1)'(1);
      end else if (w_pop_acc && !w_push_acc) begin
        r_count <= r_count - (ADDR_WIDTH+1)'(1);
      end

      if (w_err_evt) begin
        error <= 1'b1;
      end
    end
  end

`ifdef FIFO_C_ALMOST_FLAGS_EN
  assign almost_full  = (r_count >= (ADDR_WIDTH+1)'(AFULL_TH));
  assign almost_empty = (r_count <= (ADDR_WIDTH+1)'(AEMPTY_TH));
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/fifo_c.md
# fifo_c

Synchronous 8-bit FIFO that buffers one input lane ahead of the 2:1 stream multiplexer. Two instances feed the multiplexer's lane-0 and lane-1 `data_in`/`valid_in` inputs. Each instance absorbs bursts from the producer and releases words on the consumer's `pop`. Status flags let the producer throttle and let the lane arbiter see pending data.

## Interface
- `DATA_WIDTH`, 8, word width.
- `ADDR_WIDTH`, 3, pointer width; depth = 2^ADDR_WIDTH = 8.
- `AFULL_TH`, 6, `almost_full` asserts when occupancy ≥ AFULL_TH.
- `AEMPTY_TH`, 2, `almost_empty` asserts when occupancy ≤ AEMPTY_TH.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_L` in 1: asynchronous, active-low reset.
- `data_in` in DATA_WIDTH: write word.
- `push` in 1: write request.
- `pop` in 1: read request.
- `data_out` out DATA_WIDTH: popped word, registered; feeds multiplexer `data_in_x`.
- `valid_out` out 1: `data_out` valid, registered; feeds multiplexer `valid_in_x`.
- `full` out 1: occupancy == depth.
- `empty` out 1: occupancy == 0.
- `almost_full` out 1: occupancy ≥ AFULL_TH.
- `almost_empty` out 1: occupancy ≤ AEMPTY_TH.
- `error` out 1: sticky overflow/underflow flag.

## Operation
- Storage: 2^ADDR_WIDTH × DATA_WIDTH register array.
- Pointers: write pointer `wr_ptr` and read pointer `rd_ptr`, each ADDR_WIDTH bits, natural wrap from depth-1 to 0.
- Occupancy: counter `count`, ADDR_WIDTH+1 bits, range 0..depth.
- Push is accepted when `push` && (!full || pop_accepted). An accepted push writes `mem[wr_ptr]` and increments `wr_ptr`.
- Pop is accepted when `pop` && !empty. An accepted pop latches `mem[rd_ptr]` into `data_out`, sets `valid_out`=1 and increments `rd_ptr`.
- Cycles with no accepted pop: `data_out`=0, `valid_out`=0.
- Count update: +1 for push only, −1 for pop only, unchanged for both or neither.
- Simultaneous push and pop while full: both accepted, count stays at depth, no error.
- Simultaneous push and pop while empty: push accepted, pop rejected, `error` set, count goes 0→1. The written word is not bypassed to the output.
- Push while full without pop: word dropped, pointers and count unchanged, `error` set.
- Pop while empty: `valid_out`=0, pointers unchanged, `error` set.
- `error` stays 1 until `reset_L` asserts.
- Flags are combinational decodes of the registered `count`: `full`=(count==depth), `empty`=(count==0).
- Flags never glitch mid-cycle relative to `clk`.

## Timing
- Reset (async, `reset_L`=0) forces: `wr_ptr`=0, `rd_ptr`=0, `count`=0, `data_out`=0, `valid_out`=0, `error`=0.
- Resulting flag values during and after reset: `empty`=1, `full`=0, `almost_empty`=1 (with macro), `almost_full`=0.
- Memory contents are not reset.
- Reset mid-operation discards all stored words immediately; no handshake is needed.
- Deassertion is sampled at the next rising edge.
- Write latency: a word pushed at edge N is poppable at edge N+1 (`empty` drops after edge N).
- Read latency: with `pop` sampled high at edge N, `data_out`/`valid_out` are valid from after edge N until edge N+1.
- Back-to-back pops produce one word per cycle.
- Flags reflect `count` after each edge, with no further lag.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- Macro `FIFO_C_ALMOST_FLAGS_EN`.
- Defined: `almost_full` and `almost_empty` decode from `count` against AFULL_TH/AEMPTY_TH as above.
- Undefined: threshold comparators are not synthesized, and `almost_full`=0 and `almost_empty`=0 constantly, including during reset. `full`, `empty` and `error` are unaffected.

## Test plan
- Reset then idle:
  - Hold `reset_L`=0 for 2 cycles.
  - Required: `empty`=1, `full`=0, `valid_out`=0, `data_out`=0, `error`=0.
  - Release; outputs unchanged with no push or pop.
- Fill and drain:
  - Push 0x10..0x17 on 8 consecutive edges: `full`=1 after the 8th; `almost_full`=1 after the 6th.
  - Pop 8 times: `data_out` sequence 0x10..0x17, `valid_out`=1 for 8 cycles, then `empty`=1.
  - `almost_empty`=1 once count ≤ 2.
- Overflow:
  - With the FIFO full, push 0xAA without pop: `error`=1, count stays 8.
  - Subsequent 8 pops return the original words; 0xAA never appears.
- Underflow and simultaneous push/pop:
  - Empty FIFO, push=1 with 0x55 and pop=1 in the same cycle: `valid_out`=0, `error`=1, count=1.
  - Next pop returns 0x55.
- Full with push+pop and pointer wrap:
  - Full FIFO holding 0x20..0x27, push 0x30 + pop together: `data_out`=0x20, `full` stays 1.
  - Repeat 8 times with 0x30..0x37, then drain: 0x30..0x37 in order (pointer wrap verified).
- Async reset mid-stream:
  - After 4 pushes, drop `reset_L` between clock edges.
  - Required: `empty`=1 and `valid_out`=0 immediately, without waiting for a clock edge.
  - After release, a pop gives `valid_out`=0 and `error`=1.
